median_wakeup_ctrl: RTL and testbench

MEDIAN_WAKEUP_CTRL -- requirements
Module: median_wakeup_ctrl

---
 rtl/median_pkg.sv | 22 ++
 rtl/wake_hysteresis.sv | 74 +++++++
 rtl/median_wakeup_ctrl.sv | 138 +++++++++++++
 tb/tb_median_wakeup_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : median_pkg                                                   |
// | Description : Shared state encoding and parameter defaults for the median |
// |               wake-up controller.                                          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package median_pkg;

    localparam int c_WIN_COLS  = 80;
    localparam int c_WIN_ROWS  = 60;
    localparam int c_CNT_W     = 13;
    localparam int c_PERSIST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EVAL  = 2'd2
    } state_t;

endpackage : median_pkg
`default_nettype wire

// File: rtl/wake_hysteresis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wake_hysteresis                                              |
// | Description : Frame-count streak tracking with high/low thresholds and a   |
// |               persistence requirement driving a registered wake request.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module wake_hysteresis #(
    parameter int CNT_W     = 13,
    parameter int PERSIST_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_W-1:0]     count,
    input  logic [CNT_W-1:0]     thresholdHigh,
    input  logic [CNT_W-1:0]     thresholdLow,
    input  logic [PERSIST_W-1:0] persist,
    input  logic                 evaluate,
    input  logic                 clear,
    output logic                 wakeUp
);

    localparam logic [PERSIST_W-1:0] c_STREAK_MAX = '1;

    logic [PERSIST_W-1:0] r_riseStreak;
    logic [PERSIST_W-1:0] r_fallStreak;
    logic                 r_wakeUp;
    logic [PERSIST_W-1:0] w_need;
    logic [PERSIST_W-1:0] w_riseInc;
    logic [PERSIST_W-1:0] w_fallInc;

    // A persistence of zero behaves like one frame.
    assign w_need    = (persist == '0) ? PERSIST_W'(1) : persist;
    assign w_riseInc = (r_riseStreak == c_STREAK_MAX) ? r_riseStreak : r_riseStreak + PERSIST_W'(1);
    assign w_fallInc = (r_fallStreak == c_STREAK_MAX) ? r_fallStreak : r_fallStreak + PERSIST_W'(1);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_riseStreak <= '0;
            r_fallStreak <= '0;
            r_wakeUp     <= 1'b0;
        end else if (evaluate) begin
            if (!r_wakeUp) begin
                r_fallStreak <= '0;
                if (count > thresholdHigh) begin
                    if (w_riseInc >= w_need) begin
                        r_wakeUp     <= 1'b1;
                        r_riseStreak <= '0;
                    end else begin
                        r_riseStreak <= w_riseInc;
                    end
                end else begin
                    r_riseStreak <= '0;
                end
            end else begin
                r_riseStreak <= '0;
                if (count < thresholdLow) begin
                    if (w_fallInc >= w_need) begin
                        r_wakeUp     <= 1'b0;
                        r_fallStreak <= '0;
                    end else begin
                        r_fallStreak <= w_fallInc;
                    end
                end else begin
                    r_fallStreak <= '0;
                end
            end
        end
    end

    assign wakeUp = r_wakeUp;

endmodule : wake_hysteresis
`default_nettype wire

// File: rtl/median_wakeup_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : median_wakeup_ctrl                                           |
// | Description : Accepts per-window median bits, writes the median map,       |
// |               counts active windows per frame and raises a wake request.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module median_wakeup_ctrl
    import median_pkg::*;
#(
    parameter int WIN_COLS  = c_WIN_COLS,
    parameter int WIN_ROWS  = c_WIN_ROWS,
    parameter int CNT_W     = c_CNT_W,
    parameter int PERSIST_W = c_PERSIST_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 winValid,
    input  logic                 winMedian,
    output logic                 winReady,
    input  logic [CNT_W-1:0]     thresholdHigh,
    input  logic [CNT_W-1:0]     thresholdLow,
    input  logic [PERSIST_W-1:0] persistFrames,
    output logic [7:0]           xWinAddr,
    output logic [7:0]           yWinAddr,
    output logic                 medianWrEn,
    output logic                 medianWrData,
    output logic [CNT_W-1:0]     activeCount,
    output logic                 frameDone,
    output logic                 wakeUp
);

    localparam logic [7:0] c_LAST_X = 8'(WIN_COLS - 1);
    localparam logic [7:0] c_LAST_Y = 8'(WIN_ROWS - 1);

    generate
        if (CNT_W < $clog2(WIN_COLS * WIN_ROWS + 1)) begin : g_cnt_w_check
            $error("CNT_W too narrow for WIN_COLS*WIN_ROWS");
        end
        if (WIN_COLS < 1 || WIN_COLS > 256 || WIN_ROWS < 1 || WIN_ROWS > 256) begin : g_addr_check
            $error("WIN_COLS/WIN_ROWS must fit 8-bit window addresses");
        end
    endgenerate

    state_t           r_state;
    state_t           w_nextState;
    logic [7:0]       r_xCnt;
    logic [7:0]       r_yCnt;
    logic [CNT_W-1:0] r_runCount;
    logic [CNT_W-1:0] r_activeCount;
    logic             r_frameDone;
    logic             w_accept;
    logic             w_lastWin;
    logic             w_evalStrobe;

    assign winReady     = (r_state == ST_COUNT);
    assign w_accept     = winValid & winReady;
    assign w_lastWin    = (r_xCnt == c_LAST_X) && (r_yCnt == c_LAST_Y);
    assign w_evalStrobe = (r_state == ST_EVAL) && start;

    assign medianWrEn   = w_accept;
    assign medianWrData = winMedian;
    assign xWinAddr     = r_xCnt;
    assign yWinAddr     = r_yCnt;
    assign activeCount  = r_activeCount;
    assign frameDone    = r_frameDone;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  w_nextState = ST_COUNT;
            ST_COUNT: if (w_accept && w_lastWin) w_nextState = ST_EVAL;
            ST_EVAL:  w_nextState = ST_COUNT;
            default:  w_nextState = ST_IDLE;
        endcase
        if (!start) begin
            w_nextState = ST_IDLE;
        end
    end

    // Dropping start abandons the frame but keeps the last completed count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_xCnt        <= '0;
            r_yCnt        <= '0;
            r_runCount    <= '0;
            r_activeCount <= '0;
            r_frameDone   <= 1'b0;
        end else if (!start) begin
            r_xCnt      <= '0;
            r_yCnt      <= '0;
            r_runCount  <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (w_accept) begin
                r_runCount <= r_runCount + {{(CNT_W-1){1'b0}}, winMedian};
                if (r_xCnt == c_LAST_X) begin
                    r_xCnt <= '0;
                    r_yCnt <= (r_yCnt == c_LAST_Y) ? 8'd0 : r_yCnt + 8'd1;
                end else begin
                    r_xCnt <= r_xCnt + 8'd1;
                end
            end
            if (r_state == ST_EVAL) begin
                r_activeCount <= r_runCount;
                r_frameDone   <= 1'b1;
                r_runCount    <= '0;
            end
        end
    end

    wake_hysteresis #(
        .CNT_W     (CNT_W),
        .PERSIST_W (PERSIST_W)
    ) u_wake_hysteresis (
        .clk           (clk),
        .reset         (reset),
        .count         (r_runCount),
        .thresholdHigh (thresholdHigh),
        .thresholdLow  (thresholdLow),
        .persist       (persistFrames),
        .evaluate      (w_evalStrobe),
        .clear         (!start),
        .wakeUp        (wakeUp)
    );

endmodule : median_wakeup_ctrl
`default_nettype wire

// File: tb/tb_median_wakeup_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_median_wakeup_ctrl                                        |
// | Description : Scoreboard bench for median_wakeup_ctrl on a 4x2 window map. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_median_wakeup_ctrl;

    localparam int WC = 4;
    localparam int WR = 2;
    localparam int CW = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          winValid;
    logic          winMedian;
    logic          winReady;
    logic [CW-1:0] thresholdHigh;
    logic [CW-1:0] thresholdLow;
    logic [PW-1:0] persistFrames;
    logic [7:0]    xWinAddr;
    logic [7:0]    yWinAddr;
    logic          medianWrEn;
    logic          medianWrData;
    logic [CW-1:0] activeCount;
    logic          frameDone;
    logic          wakeUp;

    median_wakeup_ctrl #(
        .WIN_COLS (WC), .WIN_ROWS (WR), .CNT_W (CW), .PERSIST_W (PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .winValid      (winValid),
        .winMedian     (winMedian),
        .winReady      (winReady),
        .thresholdHigh (thresholdHigh),
        .thresholdLow  (thresholdLow),
        .persistFrames (persistFrames),
        .xWinAddr      (xWinAddr),
        .yWinAddr      (yWinAddr),
        .medianWrEn    (medianWrEn),
        .medianWrData  (medianWrData),
        .activeCount   (activeCount),
        .frameDone     (frameDone),
        .wakeUp        (wakeUp)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int d; } wr_t;
    typedef struct { int cnt; int wake; } frame_t;

    wr_t    wrQ[$];
    frame_t frQ[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int lastWr = -100;

    // Reference model state
    int mX = 0, mY = 0;
    int mWake = 0, mRise = 0, mFall = 0;
    int mActive = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mkPat(input int k);
        logic [7:0] p;
        p = '0;
        while ($countones(p) < k) p[$urandom_range(0, 7)] = 1'b1;
        return p;
    endfunction

    task automatic evalFrame(input int cnt, input int hi, input int lo, input int p);
        int need;
        need = (p == 0) ? 1 : p;
        if (mWake == 0) begin
            mFall = 0;
            mRise = (cnt > hi) ? ((mRise < 15) ? mRise + 1 : 15) : 0;
            if (mRise >= need) begin mWake = 1; mRise = 0; end
        end else begin
            mRise = 0;
            mFall = (cnt < lo) ? ((mFall < 15) ? mFall + 1 : 15) : 0;
            if (mFall >= need) begin mWake = 0; mFall = 0; end
        end
    endtask

    task automatic resetModel();
        mX = 0; mY = 0; mWake = 0; mRise = 0; mFall = 0;
    endtask

    // Offer one window and wait (bounded) for it to be taken.
    task automatic sendWin(input logic m);
        logic acc;
        wr_t  e;
        e.x = mX; e.y = mY; e.d = int'(m);
        wrQ.push_back(e);
        winValid  = 1'b1;
        winMedian = m;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = winReady;
            tick();
        end
        if (!acc) chk("acceptTimeout", 0, 1);
        mX++;
        if (mX == WC) begin
            mX = 0;
            mY = (mY == WR - 1) ? 0 : mY + 1;
        end
    endtask

    task automatic idleCycle();
        winValid  = 1'b0;
        winMedian = 1'($urandom);
        tick();
    endtask

    // Thresholds change after the first acceptance, so they land mid-frame
    // and govern only this frame's evaluation.
    task automatic runFrame(input logic [7:0] pat, input int hi, input int lo, input int p,
                            input bit gaps);
        frame_t f;
        for (int i = 0; i < WC * WR; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idleCycle();
            sendWin(pat[i]);
            if (i == 0) begin
                thresholdHigh = CW'(hi);
                thresholdLow  = CW'(lo);
                persistFrames = PW'(p);
            end
        end
        evalFrame($countones(pat), hi, lo, p);
        f.cnt = $countones(pat);
        f.wake = mWake;
        frQ.push_back(f);
        mActive = f.cnt;
        chk("evalReady", int'(winReady), 0);
        chk("evalNoWrite", int'(medianWrEn), 0);
    endtask

    task automatic framesWithCount(input int counts[$]);
        foreach (counts[i]) runFrame(mkPat(counts[i]), 4, 2, 3, 1'b0);
    endtask

    // Monitor: frameDone is handled before writes so lastWr still points at
    // the previous frame's final window when the next frame's first write
    // coincides with frameDone.
    initial begin
        wr_t    e;
        frame_t f;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset && frameDone) begin
                if (frQ.size() == 0) begin
                    chk("unexpectedFrameDone", 1, 0);
                end else begin
                    f = frQ.pop_front();
                    chk("activeCount", int'(activeCount), f.cnt);
                    chk("wakeAtFrame", int'(wakeUp), f.wake);
                    chk("frameLatency", cycle - lastWr, 2);
                end
            end
            if (medianWrEn) begin
                lastWr = cycle;
                if (wrQ.size() == 0) begin
                    chk("unexpectedWrite", 1, 0);
                end else begin
                    e = wrQ.pop_front();
                    chk("wrX", int'(xWinAddr), e.x);
                    chk("wrY", int'(yWinAddr), e.y);
                    chk("wrData", int'(medianWrData), e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; winValid = 1'b0; winMedian = 1'b0;
        thresholdHigh = CW'(4); thresholdLow = CW'(2); persistFrames = PW'(3);
        repeat (3) tick();
        chk("rstReady", int'(winReady), 0);
        chk("rstActive", int'(activeCount), 0);
        chk("rstFrameDone", int'(frameDone), 0);
        chk("rstWake", int'(wakeUp), 0);
        chk("rstX", int'(xWinAddr), 0);
        chk("rstY", int'(yWinAddr), 0);
        reset = 1'b1;
        start = 1'b1;

        // Reference pattern then rise to wake with persistence 3
        runFrame(8'b1100_1011, 4, 2, 3, 1'b0);
        framesWithCount('{5, 5});
        framesWithCount('{3, 1, 1, 1});
        framesWithCount('{5, 5, 4, 5});
        framesWithCount('{5, 5});
        framesWithCount('{1, 2, 1, 1, 1});
        framesWithCount('{5, 5, 5});

        // Synchronous reset mid-frame while awake
        sendWin(1'b1); sendWin(1'b0); sendWin(1'b1);
        winValid = 1'b0;
        reset = 1'b0;
        tick();
        resetModel();
        mActive = 0;
        chk("midRstActive", int'(activeCount), mActive);
        chk("midRstFrameDone", int'(frameDone), 0);
        chk("midRstWake", int'(wakeUp), mWake);
        chk("midRstReady", int'(winReady), 0);
        reset = 1'b1;
        winValid = 1'b1;
        #1;
        chk("postRstReady", int'(winReady), 0);
        chk("postRstWrEn", int'(medianWrEn), 0);
        winValid = 1'b0;

        // Wake again, then abandon a frame by dropping start
        framesWithCount('{6, 7, 8});
        for (int i = 0; i < 5; i++) sendWin(1'($urandom));
        start = 1'b0;
        winValid = 1'b0;
        tick();
        resetModel();
        chk("abortWake", int'(wakeUp), mWake);
        chk("abortReady", int'(winReady), 0);
        chk("abortActiveKept", int'(activeCount), mActive);
        start = 1'b1;
        framesWithCount('{0, 8});

        // Randomised frames, thresholds and persistence with input gaps
        for (int n = 0; n < 30; n++) begin
            runFrame(mkPat($urandom_range(0, 8)), $urandom_range(0, 8), $urandom_range(0, 8),
                     $urandom_range(0, 3), 1'b1);
        end

        winValid = 1'b0;
        repeat (5) tick();
        chk("wrQueueDrained", wrQ.size(), 0);
        chk("frameQueueDrained", frQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_median_wakeup_ctrl
`default_nettype wire
